idex_pipe_stage: RTL and testbench

IDEX_PIPE_STAGE -- requirements
Module: idex_pipe_stage

---
 rtl/idex_pkg.sv | 32 +++
 rtl/idex_slot.sv | 33 +++
 rtl/idex_pipe_stage.sv | 131 +++++++++++++
 tb/tb_idex_pipe_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/idex_pkg.sv
// Shared defaults and payload packing for the ID/EX pipeline stage.
// Payload layout, LSB first: opidx | opval | imm | ctrl.
package idex_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned NUM_OPS_DEF = 6;
  localparam int unsigned IDX_W_DEF   = 3;
  localparam int unsigned CTRL_W_DEF  = 16;
  localparam int unsigned CNT_W_DEF   = 16;

  localparam int unsigned OPIDX_OFF = 0;

  function automatic int unsigned opvalOffset(int unsigned numOps, int unsigned idxW);
    return numOps * idxW;
  endfunction

  function automatic int unsigned immOffset(int unsigned dataW, int unsigned numOps,
                                            int unsigned idxW);
    return opvalOffset(numOps, idxW) + numOps * dataW;
  endfunction

  function automatic int unsigned ctrlOffset(int unsigned dataW, int unsigned numOps,
                                             int unsigned idxW);
    return immOffset(dataW, numOps, idxW) + dataW;
  endfunction

  function automatic int unsigned payloadWidth(int unsigned dataW, int unsigned numOps,
                                               int unsigned idxW, int unsigned ctrlW);
    return ctrlOffset(dataW, numOps, idxW) + ctrlW;
  endfunction

endpackage

// File: rtl/idex_slot.sv
// One pipeline entry slot: payload register with load enable plus a valid flop.
module idex_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         valid_i,
  output logic [W-1:0] data_o,
  output logic         valid_o
);

  logic [W-1:0] data_q;
  logic         valid_q;

  // valid_i is the next-state valid; the payload only changes when loaded
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (load_i) begin
        data_q <= data_i;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/idex_pipe_stage.sv
// ID/EX pipeline register with a skid slot, so in_ready comes straight from a flop
// while one entry per cycle still flows when EX is ready.
module idex_pipe_stage
  import idex_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned NUM_OPS = NUM_OPS_DEF,
  parameter int unsigned IDX_W   = IDX_W_DEF,
  parameter int unsigned CTRL_W  = CTRL_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [DATA_W-1:0]         in_imm,
  input  logic [NUM_OPS*DATA_W-1:0] in_opval,
  input  logic [NUM_OPS*IDX_W-1:0]  in_opidx,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [DATA_W-1:0]         out_imm,
  output logic [NUM_OPS*DATA_W-1:0] out_opval,
  output logic [NUM_OPS*IDX_W-1:0]  out_opidx,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int unsigned PAY_W     = payloadWidth(DATA_W, NUM_OPS, IDX_W, CTRL_W);
  localparam int unsigned OPVAL_OFF = opvalOffset(NUM_OPS, IDX_W);
  localparam int unsigned IMM_OFF   = immOffset(DATA_W, NUM_OPS, IDX_W);
  localparam int unsigned CTRL_OFF  = ctrlOffset(DATA_W, NUM_OPS, IDX_W);

  logic [PAY_W-1:0] inPayload;
  logic [PAY_W-1:0] mainData;
  logic [PAY_W-1:0] skidData;
  logic [PAY_W-1:0] mainLoadData;
  logic             mainValid;
  logic             skidValid;
  logic             mainLoad;
  logic             skidLoad;
  logic             mainValidNext;
  logic             skidValidNext;
  logic             acceptFire;
  logic             consumeFire;
  logic [CNT_W-1:0] stallCnt_q;
  logic [CNT_W-1:0] stallCnt_d;

  always_comb begin
    inPayload = '0;
    inPayload[OPIDX_OFF +: NUM_OPS*IDX_W]  = in_opidx;
    inPayload[OPVAL_OFF +: NUM_OPS*DATA_W] = in_opval;
    inPayload[IMM_OFF   +: DATA_W]         = in_imm;
    inPayload[CTRL_OFF  +: CTRL_W]         = in_ctrl;
  end

  assign in_ready    = ~skidValid;
  assign acceptFire  = in_valid & in_ready;
  assign consumeFire = mainValid & out_ready;

  // Skid drains into main before any new entry can reach main; flush kills every move
  always_comb begin
    mainLoad      = 1'b0;
    skidLoad      = 1'b0;
    mainLoadData  = inPayload;
    mainValidNext = mainValid & ~consumeFire;
    skidValidNext = skidValid & ~consumeFire;
    if (consumeFire && skidValid) begin
      mainLoad      = 1'b1;
      mainLoadData  = skidData;
      mainValidNext = 1'b1;
    end else if (acceptFire && (!mainValid || consumeFire)) begin
      mainLoad      = 1'b1;
      mainValidNext = 1'b1;
    end else if (acceptFire) begin
      skidLoad      = 1'b1;
      skidValidNext = 1'b1;
    end
    if (flush) begin
      mainLoad      = 1'b0;
      skidLoad      = 1'b0;
      mainValidNext = 1'b0;
      skidValidNext = 1'b0;
    end
  end

  idex_slot #(.W(PAY_W)) mainSlot (
    .clk     (clk),
    .reset   (reset),
    .load_i  (mainLoad),
    .data_i  (mainLoadData),
    .valid_i (mainValidNext),
    .data_o  (mainData),
    .valid_o (mainValid)
  );

  idex_slot #(.W(PAY_W)) skidSlot (
    .clk     (clk),
    .reset   (reset),
    .load_i  (skidLoad),
    .data_i  (inPayload),
    .valid_i (skidValidNext),
    .data_o  (skidData),
    .valid_o (skidValid)
  );

  always_comb begin
    stallCnt_d = stallCnt_q;
    if (mainValid && !out_ready && (stallCnt_q != {CNT_W{1'b1}})) begin
      stallCnt_d = stallCnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
    end
  end

  // A bubble must look like a NOP to EX, so ctrl is masked while main is empty
  assign out_valid = mainValid;
  assign out_ctrl  = mainValid ? mainData[CTRL_OFF +: CTRL_W] : '0;
  assign out_imm   = mainData[IMM_OFF +: DATA_W];
  assign out_opval = mainData[OPVAL_OFF +: NUM_OPS*DATA_W];
  assign out_opidx = mainData[OPIDX_OFF +: NUM_OPS*IDX_W];
  assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_idex_pipe_stage.sv
// Directed bench for idex_pipe_stage: vector table for streaming and back-pressure,
// hand-written sequences for flush, counter saturation and reset mid-operation.
module tb_idex_pipe_stage;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_OPS = 6;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CTRL_W  = 16;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned NVEC    = 17;

  logic                      clk;
  logic                      reset;
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [CTRL_W-1:0]         in_ctrl;
  logic [DATA_W-1:0]         in_imm;
  logic [NUM_OPS*DATA_W-1:0] in_opval;
  logic [NUM_OPS*IDX_W-1:0]  in_opidx;
  logic                      out_valid;
  logic                      out_ready;
  logic [CTRL_W-1:0]         out_ctrl;
  logic [DATA_W-1:0]         out_imm;
  logic [NUM_OPS*DATA_W-1:0] out_opval;
  logic [NUM_OPS*IDX_W-1:0]  out_opidx;
  logic [CNT_W-1:0]          stall_cnt;

  int cmpCount;
  int failCount;

  typedef struct {
    logic              flush;
    logic              inValid;
    logic              outReady;
    logic [DATA_W-1:0] inImm;
    logic              expValid;
    logic              expReady;
    logic [DATA_W-1:0] expImm;
    logic [CNT_W-1:0]  expStall;
    logic              checkPay;
  } vec_t;

  vec_t vecs [NVEC];

  idex_pipe_stage #(
    .DATA_W  (DATA_W),
    .NUM_OPS (NUM_OPS),
    .IDX_W   (IDX_W),
    .CTRL_W  (CTRL_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_imm    (in_imm),
    .in_opval  (in_opval),
    .in_opidx  (in_opidx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_imm   (out_imm),
    .out_opval (out_opval),
    .out_opidx (out_opidx),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every payload field is derived from the immediate so one number tags an entry
  function automatic logic [CTRL_W-1:0] mkCtrl(logic [DATA_W-1:0] imm);
    return 16'hC000 | imm[15:0];
  endfunction

  function automatic logic [NUM_OPS*DATA_W-1:0] mkOpval(logic [DATA_W-1:0] imm);
    logic [NUM_OPS*DATA_W-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_OPS; k++) v[k*DATA_W +: DATA_W] = imm * DATA_W'(k + 1);
    return v;
  endfunction

  function automatic logic [NUM_OPS*IDX_W-1:0] mkOpidx(logic [DATA_W-1:0] imm);
    logic [NUM_OPS*IDX_W-1:0] v;
    logic [DATA_W-1:0]        prod;
    v = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      prod = imm * DATA_W'(k + 1);
      v[k*IDX_W +: IDX_W] = prod[IDX_W-1:0];
    end
    return v;
  endfunction

  task automatic applyStimulus(input logic fl, input logic iv, input logic ordy,
                               input logic [DATA_W-1:0] imm);
    flush     = fl;
    in_valid  = iv;
    out_ready = ordy;
    in_imm    = imm;
    in_ctrl   = mkCtrl(imm);
    in_opval  = mkOpval(imm);
    in_opidx  = mkOpidx(imm);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkField(input string nm, input logic [255:0] act, input logic [255:0] exp);
    cmpCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic expValid, input logic expReady,
                             input logic [DATA_W-1:0] expImm, input logic [CNT_W-1:0] expStall,
                             input logic checkPay);
    logic [CTRL_W-1:0] expCtrl;
    expCtrl = expValid ? mkCtrl(expImm) : '0;
    checkField({tag, ".out_valid"}, 256'(out_valid), 256'(expValid));
    checkField({tag, ".in_ready"}, 256'(in_ready), 256'(expReady));
    checkField({tag, ".out_ctrl"}, 256'(out_ctrl), 256'(expCtrl));
    checkField({tag, ".stall_cnt"}, 256'(stall_cnt), 256'(expStall));
    if (checkPay) begin
      checkField({tag, ".out_imm"}, 256'(out_imm), 256'(expImm));
      checkField({tag, ".out_opval"}, 256'(out_opval), 256'(mkOpval(expImm)));
      checkField({tag, ".out_opidx"}, 256'(out_opidx), 256'(mkOpidx(expImm)));
    end
  endtask

  initial begin
    cmpCount  = 0;
    failCount = 0;
    reset     = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd99);

    // Streaming 1..8 with EX always ready, then one bubble that keeps the old payload
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{1'b0, 1'b1, 1'b1, DATA_W'(i + 1), 1'b1, 1'b1, DATA_W'(i + 1), 4'd0, 1'b1};
    end
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'd0,  1'b0, 1'b1, 32'd8,  4'd0, 1'b1};
    // Back-pressure: 5 cycles not ready while offering 11, 12, 13
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'd11, 1'b1, 1'b1, 32'd11, 4'd0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'd12, 1'b1, 1'b0, 32'd11, 4'd1, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'd13, 1'b1, 1'b0, 32'd11, 4'd2, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 32'd13, 1'b1, 1'b0, 32'd11, 4'd3, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 32'd13, 1'b1, 1'b0, 32'd11, 4'd4, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 32'd13, 1'b1, 1'b1, 32'd12, 4'd4, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 32'd13, 1'b1, 1'b1, 32'd13, 4'd4, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 32'd0,  1'b0, 1'b1, 32'd13, 4'd4, 1'b1};

    // Reset held two cycles with traffic on the inputs
    for (int r = 0; r < 2; r++) begin
      stepCycle();
      checkOutput($sformatf("reset%0d", r), 1'b0, 1'b1, 32'd0, 4'd0, 1'b1);
    end
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].flush, vecs[i].inValid, vecs[i].outReady, vecs[i].inImm);
      stepCycle();
      checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expReady,
                  vecs[i].expImm, vecs[i].expStall, vecs[i].checkPay);
    end

    // Flush with both slots full and a new entry offered
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    stepCycle();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd21);
    stepCycle();
    checkOutput("flushFill0", 1'b1, 1'b1, 32'd21, 4'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd22);
    stepCycle();
    checkOutput("flushFill1", 1'b1, 1'b0, 32'd21, 4'd1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd23);
    stepCycle();
    checkOutput("flushHit", 1'b0, 1'b1, 32'd0, 4'd2, 1'b0);
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
      stepCycle();
      checkOutput($sformatf("flushDrain%0d", j), 1'b0, 1'b1, 32'd0, 4'd2, 1'b0);
    end
    // An entry accepted in the flush cycle itself is discarded
    applyStimulus(1'b1, 1'b1, 1'b1, 32'd24);
    stepCycle();
    checkOutput("flushAccept", 1'b0, 1'b1, 32'd0, 4'd2, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
    stepCycle();
    checkOutput("flushAcceptGone", 1'b0, 1'b1, 32'd0, 4'd2, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd25);
    stepCycle();
    checkOutput("postFlush", 1'b1, 1'b1, 32'd25, 4'd2, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
    stepCycle();
    checkOutput("postFlushIdle", 1'b0, 1'b1, 32'd25, 4'd2, 1'b0);

    // Saturation of the 4-bit stall counter
    reset = 1'b1;
    stepCycle();
    checkOutput("satReset", 1'b0, 1'b1, 32'd0, 4'd0, 1'b1);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd31);
    stepCycle();
    checkOutput("satLoad", 1'b1, 1'b1, 32'd31, 4'd0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      stepCycle();
      checkOutput($sformatf("sat%0d", k), 1'b1, 1'b1, 32'd31,
                  (k >= 15) ? 4'd15 : 4'(k), 1'b1);
    end

    // Reset with skid full, flush and traffic all asserted
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd32);
    stepCycle();
    checkOutput("midFill", 1'b1, 1'b0, 32'd31, 4'd15, 1'b1);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'd33);
    stepCycle();
    checkOutput("midReset", 1'b0, 1'b1, 32'd0, 4'd0, 1'b1);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
    stepCycle();
    checkOutput("midAfter", 1'b0, 1'b1, 32'd0, 4'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
